// File: rtl/jtdd_sched_pkg.sv
// Shared types and sizes for the jtdd SDRAM slot scheduler.
package jtdd_sched_pkg;

  localparam int unsigned NCLI = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned DW   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/jtdd_sched_grant.sv
// Client grant selection: round-robin when JTDD_SCHED_RR_EN is defined,
// otherwise fixed priority 0 > 1 > 2 > 3.
module jtdd_sched_grant
  import jtdd_sched_pkg::*;
(
  input  logic [NCLI-1:0] pend,
  input  logic [CW-1:0]   last,
  output logic [NCLI-1:0] gnt,
  output logic [CW-1:0]   idx
);

`ifdef JTDD_SCHED_RR_EN
  logic [CW-1:0] cand;

  // Walk backwards so the client right after last ends up winning.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = int'(NCLI); k >= 1; k--) begin
      cand = last + CW'(k);
      if (pend[cand]) idx = cand;
    end
    if (|pend) gnt[idx] = 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = int'(NCLI) - 1; k >= 0; k--) begin
      if (pend[k]) idx = CW'(k);
    end
    if (|pend) gnt[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/jtdd_slot_sched.sv
// Four-client SDRAM read scheduler with a one-word cache per client.
// Build option: JTDD_SCHED_RR_EN selects round-robin grant.
module jtdd_slot_sched
  import jtdd_sched_pkg::*;
#(
  parameter int unsigned AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          cs0,
  input  logic          cs1,
  input  logic          cs2,
  input  logic          cs3,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  output logic          ok0,
  output logic          ok1,
  output logic          ok2,
  output logic          ok3,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic [DW-1:0] dout3,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [DW-1:0] data_read,
  output logic          refresh_en
);

  state_t          state;
  logic [NCLI-1:0] cs, hit, pend, valid, gnt;
  logic [AW-1:0]   addr [NCLI];
  logic [AW-1:0]   tag  [NCLI];
  logic [DW-1:0]   data [NCLI];
  logic [CW-1:0]   last, idx, sel;

  assign cs      = {cs3, cs2, cs1, cs0};
  assign addr[0] = addr0;
  assign addr[1] = addr1;
  assign addr[2] = addr2;
  assign addr[3] = addr3;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NCLI); i++) begin
      hit[i] = cs[i] & valid[i] & (addr[i] == tag[i]);
    end
  end

  assign pend  = cs & ~hit;
  assign ok0   = hit[0];
  assign ok1   = hit[1];
  assign ok2   = hit[2];
  assign ok3   = hit[3];
  assign dout0 = data[0];
  assign dout1 = data[1];
  assign dout2 = data[2];
  assign dout3 = data[3];

  assign refresh_en = ((state == IDLE) && (pend == '0)) || downloading;

  jtdd_sched_grant u_grant (
    .pend (pend),
    .last (last),
    .gnt  (gnt),
    .idx  (idx)
  );

  // Transaction sequencer; the fill always targets the client latched in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel        <= '0;
      last       <= CW'(NCLI - 1);
      valid      <= '0;
      for (int i = 0; i < int'(NCLI); i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (downloading) begin
      state     <= IDLE;
      sdram_req <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            sel        <= idx;
            last       <= idx;
            sdram_addr <= addr[idx];
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              data[sel]  <= data_read;
              tag[sel]   <= sdram_addr;
              valid[sel] <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_rdy) begin
            data[sel]  <= data_read;
            tag[sel]   <= sdram_addr;
            valid[sel] <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_slot_sched.sv
// Scoreboard bench for jtdd_slot_sched: expected fills are queued as requests
// are driven and checked as the scheduler issues and completes them.
module tb_jtdd_slot_sched;

  localparam int unsigned AW = 22;

  typedef struct {
    int          cli;
    logic [21:0] addr;
    logic [31:0] data;
    bit          exp_ok;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          downloading = 1'b0;
  logic [3:0]    cs = '0;
  logic [AW-1:0] addr [4];
  logic [3:0]    ok;
  logic [31:0]   dout [4];
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack = 1'b0;
  logic          data_rdy = 1'b0;
  logic [31:0]   data_read = '0;
  logic          refresh_en;

  ent_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jtdd_slot_sched #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .cs0(cs[0]), .cs1(cs[1]), .cs2(cs[2]), .cs3(cs[3]),
    .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
    .ok0(ok[0]), .ok1(ok[1]), .ok2(ok[2]), .ok3(ok[3]),
    .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dgen(input logic [21:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic push(input int cli, input logic [21:0] a, input logic [31:0] d, input bit eok);
    ent_t e;
    e.cli = cli; e.addr = a; e.data = d; e.exp_ok = eok;
    exp_q.push_back(e);
  endtask

  // Act as the SDRAM controller for the next queued transaction.
  task automatic serve(input int exp_wait, input int ack_dly, input int rdy_dly,
                       input bit same, input bit chg, input logic [21:0] new_addr);
    ent_t e;
    int   n;
    e = exp_q.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_req && n < 20);
    chk("req_seen", 64'(sdram_req), 64'(1));
    if (exp_wait > 0) chk("req_latency", 64'(n), 64'(exp_wait));
    chk("req_addr", 64'(sdram_addr), 64'(e.addr));
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_hold", 64'({sdram_req, sdram_addr}), 64'({1'b1, e.addr}));
    end
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy  = 1'b1;
      data_read = e.data;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    chk("req_drop", 64'(sdram_req), 64'(0));
    if (chg) addr[e.cli] = new_addr;
    if (!same) begin
      repeat (rdy_dly - 1) @(negedge clk);
      data_rdy  = 1'b1;
      data_read = e.data;
      @(negedge clk);
      data_rdy  = 1'b0;
      data_read = '0;
    end
    #1;
    chk($sformatf("ok%0d_fill", e.cli), 64'(ok[e.cli]), 64'(e.exp_ok));
    if (e.exp_ok) chk($sformatf("dout%0d_fill", e.cli), 64'(dout[e.cli]), 64'(e.data));
    chk("idle_gap", 64'(sdram_req), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) addr[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ok", 64'(ok), 64'(0));
    chk("rst_req", 64'(sdram_req), 64'(0));
    chk("rst_addr", 64'(sdram_addr), 64'(0));
    chk("rst_refresh", 64'(refresh_en), 64'(1));
    chk("rst_dout0", 64'(dout[0]), 64'(0));

    // Single miss, then zero-latency hit with no SDRAM traffic.
    @(negedge clk);
    cs[0] = 1'b1; addr[0] = 22'h1234;
    push(0, 22'h1234, 32'hDEADBEEF, 1'b1);
    serve(1, 2, 3, 1'b0, 1'b0, '0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("hit_ok0", 64'(ok[0]), 64'(1));
      chk("hit_noreq", 64'(sdram_req), 64'(0));
    end

    // Simultaneous misses on clients 0 and 3.
    @(negedge clk);
    cs[3] = 1'b1; addr[3] = 22'h300; addr[0] = 22'h100;
`ifdef JTDD_SCHED_RR_EN
    push(3, 22'h300, dgen(22'h300), 1'b1);
    push(0, 22'h100, dgen(22'h100), 1'b1);
`else
    push(0, 22'h100, dgen(22'h100), 1'b1);
    push(3, 22'h300, dgen(22'h300), 1'b1);
`endif
    serve(1, 1, 2, 1'b0, 1'b0, '0);
    serve(1, 1, 2, 1'b0, 1'b0, '0);
    #1;
    chk("both_hit", 64'({ok[3], ok[0]}), 64'(2'b11));

    // Address change while the fill is outstanding.
    @(negedge clk);
    cs[1] = 1'b1; addr[1] = 22'h10;
    push(1, 22'h10, dgen(22'h10), 1'b0);
    serve(1, 1, 2, 1'b0, 1'b1, 22'h20);
    addr[1] = 22'h10; #1;
    chk("old_tag_ok1", 64'(ok[1]), 64'(1));
    chk("old_tag_dout1", 64'(dout[1]), 64'(dgen(22'h10)));
    addr[1] = 22'h20; #1;
    push(1, 22'h20, dgen(22'h20), 1'b1);
    serve(1, 1, 1, 1'b0, 1'b0, '0);

    // Download abandons the in-flight fill and flushes the cache.
    @(negedge clk);
    cs = 4'b0001;
    cs[2] = 1'b1; addr[2] = 22'h500;
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_req && n < 20);
    chk("dl_req_addr", 64'(sdram_addr), 64'(22'h500));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    downloading = 1'b1;
    @(negedge clk); #1;
    chk("dl_req", 64'(sdram_req), 64'(0));
    chk("dl_ok", 64'(ok), 64'(0));
    chk("dl_refresh", 64'(refresh_en), 64'(1));
    data_rdy = 1'b1; data_read = 32'h0BADF00D;
    @(negedge clk);
    data_rdy = 1'b0; data_read = '0;
    #1;
    chk("dl_ignore_ok2", 64'(ok[2]), 64'(0));
    cs[2] = 1'b0;
    downloading = 1'b0;
    #1;
    chk("dl_rehit_miss", 64'(ok[0]), 64'(0));
    push(0, 22'h100, dgen(22'h100), 1'b1);
    serve(1, 1, 2, 1'b0, 1'b0, '0);

    // Ack and data in the same cycle, followed by a back-to-back miss.
    @(negedge clk);
    cs[1] = 1'b1; addr[1] = 22'h30;
    cs[2] = 1'b1; addr[2] = 22'h40;
    push(1, 22'h30, dgen(22'h30), 1'b1);
    push(2, 22'h40, dgen(22'h40), 1'b1);
    serve(1, 0, 0, 1'b1, 1'b0, '0);
    serve(1, 1, 1, 1'b0, 1'b0, '0);

    // Everyone quiet: refresh allowed, no requests.
    @(negedge clk);
    cs = '0;
    repeat (8) begin
      @(negedge clk); #1;
      chk("quiet", 64'({refresh_en, sdram_req}), 64'(2'b10));
    end

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
